// File: rtl/cam_host_ctrl.sv
// Requester-side CAM controller: one command at a time, fixed-latency result sampling,
// and insert (search, then write on miss at a round-robin slot). Optional stats via CAM_HOST_STATS_EN.
module cam_host_ctrl #(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned ADDR_WIDTH = 5,
    parameter int unsigned CAM_LAT    = 1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  cmd_valid_i,
    output logic                  cmd_ready_o,
    input  logic [1:0]            cmd_op_i,
    input  logic [ADDR_WIDTH-1:0] cmd_index_i,
    input  logic [WIDTH-1:0]      cmd_data_i,
    output logic                  rsp_valid_o,
    input  logic                  rsp_ready_i,
    output logic                  rsp_hit_o,
    output logic [ADDR_WIDTH-1:0] rsp_index_o,
    output logic [WIDTH-1:0]      rsp_data_o,
    output logic                  cam_read_enable_o,
    output logic [ADDR_WIDTH-1:0] cam_read_index_o,
    output logic                  cam_write_enable_o,
    output logic [ADDR_WIDTH-1:0] cam_write_index_o,
    output logic [WIDTH-1:0]      cam_write_data_o,
    output logic                  cam_search_enable_o,
    output logic [WIDTH-1:0]      cam_search_data_o,
    input  logic                  cam_read_valid_i,
    input  logic [WIDTH-1:0]      cam_read_value_i,
    input  logic                  cam_search_valid_i,
    input  logic [ADDR_WIDTH-1:0] cam_search_index_i
`ifdef CAM_HOST_STATS_EN
    ,
    output logic [15:0]           stat_hits_o,
    output logic [15:0]           stat_misses_o
`endif
);

    typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_INSERT_WR, S_RESP} state_e;
    typedef enum logic [1:0] {OP_READ = 2'b00, OP_WRITE = 2'b01, OP_SEARCH = 2'b10, OP_INSERT = 2'b11} op_e;

    state_e                state_q, state_d;
    op_e                   op_q, op_d;
    logic [ADDR_WIDTH-1:0] idx_q, idx_d;
    logic [WIDTH-1:0]      data_q, data_d;
    logic [1:0]            cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0] alloc_q, alloc_d;
    logic                  cmd_ready_q, cmd_ready_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic                  rsp_hit_q, rsp_hit_d;
    logic [ADDR_WIDTH-1:0] rsp_index_q, rsp_index_d;
    logic [WIDTH-1:0]      rsp_data_q, rsp_data_d;
    logic                  rd_en_q, rd_en_d;
    logic [ADDR_WIDTH-1:0] rd_idx_q, rd_idx_d;
    logic                  wr_en_q, wr_en_d;
    logic [ADDR_WIDTH-1:0] wr_idx_q, wr_idx_d;
    logic [WIDTH-1:0]      wr_data_q, wr_data_d;
    logic                  sr_en_q, sr_en_d;
    logic [WIDTH-1:0]      sr_data_q, sr_data_d;
    logic [15:0]           hits_q, hits_d;
    logic [15:0]           misses_q, misses_d;

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        idx_d       = idx_q;
        data_d      = data_q;
        cnt_d       = cnt_q;
        alloc_d     = alloc_q;
        cmd_ready_d = cmd_ready_q;
        rsp_valid_d = rsp_valid_q;
        rsp_hit_d   = rsp_hit_q;
        rsp_index_d = rsp_index_q;
        rsp_data_d  = rsp_data_q;
        rd_en_d     = 1'b0;
        rd_idx_d    = rd_idx_q;
        wr_en_d     = 1'b0;
        wr_idx_d    = wr_idx_q;
        wr_data_d   = wr_data_q;
        sr_en_d     = 1'b0;
        sr_data_d   = sr_data_q;
        hits_d      = hits_q;
        misses_d    = misses_q;

        case (state_q)
            S_IDLE: begin
                // Enables are registered on accept so the pulse is high exactly during ISSUE.
                if (cmd_valid_i && cmd_ready_q) begin
                    op_d        = op_e'(cmd_op_i);
                    idx_d       = cmd_index_i;
                    data_d      = cmd_data_i;
                    cmd_ready_d = 1'b0;
                    state_d     = S_ISSUE;
                    case (op_e'(cmd_op_i))
                        OP_READ: begin
                            rd_en_d  = 1'b1;
                            rd_idx_d = cmd_index_i;
                        end
                        OP_WRITE: begin
                            wr_en_d   = 1'b1;
                            wr_idx_d  = cmd_index_i;
                            wr_data_d = cmd_data_i;
                        end
                        default: begin
                            sr_en_d   = 1'b1;
                            sr_data_d = cmd_data_i;
                        end
                    endcase
                end
            end
            S_ISSUE: begin
                cnt_d = '0;
                if (op_q == OP_WRITE) begin
                    rsp_hit_d   = 1'b1;
                    rsp_index_d = idx_q;
                    rsp_data_d  = data_q;
                    rsp_valid_d = 1'b1;
                    state_d     = S_RESP;
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (cnt_q == 2'(CAM_LAT - 1)) begin
                    rsp_data_d = data_q;
                    if (op_q == OP_READ) begin
                        rsp_hit_d   = cam_read_valid_i;
                        rsp_data_d  = cam_read_value_i;
                        rsp_index_d = idx_q;
                        rsp_valid_d = 1'b1;
                        state_d     = S_RESP;
                    end else begin
                        if (cam_search_valid_i) begin
                            if (hits_q != '1) hits_d = hits_q + 16'd1;
                        end else begin
                            if (misses_q != '1) misses_d = misses_q + 16'd1;
                        end
                        if (cam_search_valid_i || op_q == OP_SEARCH) begin
                            rsp_hit_d   = cam_search_valid_i;
                            rsp_index_d = cam_search_valid_i ? cam_search_index_i : '0;
                            rsp_valid_d = 1'b1;
                            state_d     = S_RESP;
                        end else begin
                            wr_en_d     = 1'b1;
                            wr_idx_d    = alloc_q;
                            wr_data_d   = data_q;
                            rsp_hit_d   = 1'b0;
                            rsp_index_d = alloc_q;
                            alloc_d     = alloc_q + ADDR_WIDTH'(1);
                            state_d     = S_INSERT_WR;
                        end
                    end
                end else begin
                    cnt_d = cnt_q + 2'd1;
                end
            end
            S_INSERT_WR: begin
                rsp_valid_d = 1'b1;
                state_d     = S_RESP;
            end
            S_RESP: begin
                if (rsp_ready_i) begin
                    rsp_valid_d = 1'b0;
                    cmd_ready_d = 1'b1;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q     <= S_IDLE;
            op_q        <= OP_READ;
            idx_q       <= '0;
            data_q      <= '0;
            cnt_q       <= '0;
            alloc_q     <= '0;
            cmd_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_hit_q   <= 1'b0;
            rsp_index_q <= '0;
            rsp_data_q  <= '0;
            rd_en_q     <= 1'b0;
            rd_idx_q    <= '0;
            wr_en_q     <= 1'b0;
            wr_idx_q    <= '0;
            wr_data_q   <= '0;
            sr_en_q     <= 1'b0;
            sr_data_q   <= '0;
            hits_q      <= '0;
            misses_q    <= '0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            idx_q       <= idx_d;
            data_q      <= data_d;
            cnt_q       <= cnt_d;
            alloc_q     <= alloc_d;
            cmd_ready_q <= cmd_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_hit_q   <= rsp_hit_d;
            rsp_index_q <= rsp_index_d;
            rsp_data_q  <= rsp_data_d;
            rd_en_q     <= rd_en_d;
            rd_idx_q    <= rd_idx_d;
            wr_en_q     <= wr_en_d;
            wr_idx_q    <= wr_idx_d;
            wr_data_q   <= wr_data_d;
            sr_en_q     <= sr_en_d;
            sr_data_q   <= sr_data_d;
            hits_q      <= hits_d;
            misses_q    <= misses_d;
        end
    end

    assign cmd_ready_o         = cmd_ready_q;
    assign rsp_valid_o         = rsp_valid_q;
    assign rsp_hit_o           = rsp_hit_q;
    assign rsp_index_o         = rsp_index_q;
    assign rsp_data_o          = rsp_data_q;
    assign cam_read_enable_o   = rd_en_q;
    assign cam_read_index_o    = rd_idx_q;
    assign cam_write_enable_o  = wr_en_q;
    assign cam_write_index_o   = wr_idx_q;
    assign cam_write_data_o    = wr_data_q;
    assign cam_search_enable_o = sr_en_q;
    assign cam_search_data_o   = sr_data_q;

`ifdef CAM_HOST_STATS_EN
    assign stat_hits_o   = hits_q;
    assign stat_misses_o = misses_q;
`else
    logic unused_stats;
    assign unused_stats = ^{hits_q, misses_q};
`endif

endmodule

// File: tb/tb_cam_host_ctrl.sv
// Directed bench for cam_host_ctrl with a behavioural 32-entry CAM (latency 1) attached.
module tb_cam_host_ctrl;

    logic        clk = 1'b0;
    logic        rst_i = 1'b0;
    logic        cmd_valid_i = 1'b0;
    logic        cmd_ready_o;
    logic [1:0]  cmd_op_i = '0;
    logic [4:0]  cmd_index_i = '0;
    logic [31:0] cmd_data_i = '0;
    logic        rsp_valid_o;
    logic        rsp_ready_i = 1'b0;
    logic        rsp_hit_o;
    logic [4:0]  rsp_index_o;
    logic [31:0] rsp_data_o;
    logic        cam_read_enable_o;
    logic [4:0]  cam_read_index_o;
    logic        cam_write_enable_o;
    logic [4:0]  cam_write_index_o;
    logic [31:0] cam_write_data_o;
    logic        cam_search_enable_o;
    logic [31:0] cam_search_data_o;
    logic        m_rd_v = 1'b0;
    logic [31:0] m_rd_val = '0;
    logic [5:0]  m_sr = '0;
`ifdef CAM_HOST_STATS_EN
    logic [15:0] stat_hits_o, stat_misses_o;
`endif

    always #5 clk = ~clk;

    cam_host_ctrl #(.WIDTH(32), .ADDR_WIDTH(5), .CAM_LAT(1)) dut (
        .clk_i(clk), .rst_i(rst_i),
        .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_op_i(cmd_op_i),
        .cmd_index_i(cmd_index_i), .cmd_data_i(cmd_data_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_hit_o(rsp_hit_o),
        .rsp_index_o(rsp_index_o), .rsp_data_o(rsp_data_o),
        .cam_read_enable_o(cam_read_enable_o), .cam_read_index_o(cam_read_index_o),
        .cam_write_enable_o(cam_write_enable_o), .cam_write_index_o(cam_write_index_o),
        .cam_write_data_o(cam_write_data_o),
        .cam_search_enable_o(cam_search_enable_o), .cam_search_data_o(cam_search_data_o),
        .cam_read_valid_i(m_rd_v), .cam_read_value_i(m_rd_val),
        .cam_search_valid_i(m_sr[5]), .cam_search_index_i(m_sr[4:0])
`ifdef CAM_HOST_STATS_EN
        , .stat_hits_o(stat_hits_o), .stat_misses_o(stat_misses_o)
`endif
    );

    // Behavioural CAM: results appear one cycle after the enable, lowest matching index wins.
    logic [31:0] m_mem [32];
    logic [31:0] m_vld = '0;

    function automatic logic [5:0] find(input logic [31:0] key);
        for (int i = 0; i < 32; i++)
            if (m_vld[i] && m_mem[i] == key) return {1'b1, 5'(i)};
        return '0;
    endfunction

    always @(posedge clk) begin
        if (cam_read_enable_o) begin
            m_rd_v   <= m_vld[cam_read_index_o];
            m_rd_val <= m_mem[cam_read_index_o];
        end
        if (cam_search_enable_o) m_sr <= find(cam_search_data_o);
        if (cam_write_enable_o) begin
            m_mem[cam_write_index_o] <= cam_write_data_o;
            m_vld[cam_write_index_o] <= 1'b1;
        end
    end

    int          wr_cnt = 0;
    logic [4:0]  last_wr_idx = '0;
    logic [31:0] last_wr_data = '0;
    always @(negedge clk) begin
        if (cam_write_enable_o) begin
            wr_cnt       <= wr_cnt + 1;
            last_wr_idx  <= cam_write_index_o;
            last_wr_data <= cam_write_data_o;
        end
    end

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Called at a negedge; returns at a negedge after the response handshake.
    task automatic do_cmd(input logic [1:0] op, input logic [4:0] idx, input logic [31:0] data,
                          input int hold, output int lat, output logic hit,
                          output logic [4:0] ridx, output logic [31:0] rdata);
        chk("cmd_ready_before", cmd_ready_o, 1);
        cmd_valid_i = 1'b1; cmd_op_i = op; cmd_index_i = idx; cmd_data_i = data;
        @(posedge clk); #1;
        cmd_valid_i = 1'b0;
        lat = 0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (rsp_valid_o) begin lat = k; break; end
        end
        if (lat == 0) chk("rsp_timeout", rsp_valid_o, 1);
        hit = rsp_hit_o; ridx = rsp_index_o; rdata = rsp_data_o;
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            chk("hold_valid", rsp_valid_o, 1);
            chk("hold_fields", {rsp_hit_o, rsp_index_o, rsp_data_o}, {hit, ridx, rdata});
            chk("hold_cmd_ready", cmd_ready_o, 0);
        end
        rsp_ready_i = 1'b1;
        @(posedge clk); #1;
        rsp_ready_i = 1'b0;
        @(negedge clk);
    endtask

    int          lat, w0;
    logic        hit;
    logic [4:0]  ridx;
    logic [31:0] rdata;

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_cmd_ready", cmd_ready_o, 1);
        chk("rst_outs", {rsp_valid_o, rsp_hit_o, rsp_index_o, rsp_data_o,
                         cam_read_enable_o, cam_write_enable_o, cam_search_enable_o}, 0);
        rst_i = 1'b1;
        @(negedge clk);

        w0 = wr_cnt;
        do_cmd(2'b01, 5'd3, 32'hDEADBEEF, 0, lat, hit, ridx, rdata);
        chk("wr_lat", 64'(lat), 2);
        chk("wr_rsp", {hit, ridx}, {1'b1, 5'd3});
        chk("wr_pulses", 64'(wr_cnt - w0), 1);
        chk("wr_cam", {last_wr_idx, last_wr_data}, {5'd3, 32'hDEADBEEF});

        do_cmd(2'b00, 5'd3, 32'h0, 0, lat, hit, ridx, rdata);
        chk("rd_lat", 64'(lat), 3);
        chk("rd_rsp", {hit, ridx, rdata}, {1'b1, 5'd3, 32'hDEADBEEF});

        w0 = wr_cnt;
        do_cmd(2'b10, 5'd0, 32'h12345678, 0, lat, hit, ridx, rdata);
        chk("sr_miss_lat", 64'(lat), 3);
        chk("sr_miss_rsp", {hit, ridx, rdata}, {1'b0, 5'd0, 32'h12345678});
        chk("sr_miss_nowr", 64'(wr_cnt - w0), 0);
        do_cmd(2'b10, 5'd0, 32'hDEADBEEF, 0, lat, hit, ridx, rdata);
        chk("sr_hit_rsp", {hit, ridx}, {1'b1, 5'd3});

        do_cmd(2'b00, 5'd3, 32'h0, 5, lat, hit, ridx, rdata);
        chk("hold_rsp", {hit, ridx, rdata}, {1'b1, 5'd3, 32'hDEADBEEF});
        chk("hold_next_ready", cmd_ready_o, 1);

        for (int i = 0; i < 33; i++) begin
            w0 = wr_cnt;
            do_cmd(2'b11, 5'd0, 32'h1000_0000 + 32'(i), 0, lat, hit, ridx, rdata);
            chk("ins_lat", 64'(lat), 4);
            chk("ins_rsp", {hit, ridx}, {1'b0, 5'(i % 32)});
            chk("ins_pulses", 64'(wr_cnt - w0), 1);
            chk("ins_cam", {last_wr_idx, last_wr_data}, {5'(i % 32), 32'h1000_0000 + 32'(i)});
        end
        w0 = wr_cnt;
        do_cmd(2'b11, 5'd0, 32'h1000_0002, 0, lat, hit, ridx, rdata);
        chk("ins_hit_lat", 64'(lat), 3);
        chk("ins_hit_rsp", {hit, ridx}, {1'b1, 5'd2});
        chk("ins_hit_nowr", 64'(wr_cnt - w0), 0);

        cmd_valid_i = 1'b1; cmd_op_i = 2'b11; cmd_data_i = 32'hABCD0000;
        @(posedge clk); #1;
        cmd_valid_i = 1'b0;
        @(negedge clk);
        @(negedge clk);
        w0 = wr_cnt;
        rst_i = 1'b0;
        #1;
        chk("mid_rst_ready", cmd_ready_o, 1);
        chk("mid_rst_valid", rsp_valid_o, 0);
        chk("mid_rst_wren", cam_write_enable_o, 0);
`ifdef CAM_HOST_STATS_EN
        chk("mid_rst_stats", {stat_hits_o, stat_misses_o}, 0);
`endif
        repeat (3) @(negedge clk);
        chk("mid_rst_nowr", 64'(wr_cnt - w0), 0);
        rst_i = 1'b1;
        @(negedge clk);
        w0 = wr_cnt;
        do_cmd(2'b11, 5'd0, 32'hABCD0001, 0, lat, hit, ridx, rdata);
        chk("post_rst_ins", {hit, ridx}, {1'b0, 5'd0});
        chk("post_rst_wr", {64'(wr_cnt - w0), last_wr_idx}, {64'd1, 5'd0});

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
